// File: rtl/mips_mem_pkg.sv
// Shared types for the multicycle MIPS unified-memory arbiter.
// State encoding and owner constants used by the arbiter top and its bench.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_starve_counter.sv
// Saturating count of consecutive fetch losses; sat tells the arbiter to favour fetch.
// sat is registered alongside the count so it is valid the cycle after any update.
module mem_starve_counter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (inc && (count < CNT_W'(STARVE_MAX))) begin
      count_nxt = count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= count_nxt;
      sat   <= (count_nxt >= CNT_W'(STARVE_MAX));
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data load/store.
// Data has fixed priority unless fetch has lost STARVE_MAX arbitrations in a row.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lorD_mux,
  output logic              busy
);

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e             state, state_nxt;
  logic               acc_owner, acc_owner_nxt;
  logic               acc_we, acc_we_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [DATA_W-1:0]  wdata_nxt;
  logic [DATA_W-1:0]  if_rdata_nxt, d_rdata_nxt;
  logic               if_gnt_nxt, d_gnt_nxt, if_done_nxt, d_done_nxt;
  logic               en_nxt, we_nxt, lord_nxt, busy_nxt;

  logic starve_sat;
  logic grant_d;
  logic grant_if;
  logic starve_inc;
  logic starve_clr;

  // Data wins a tie unless fetch has been starved long enough.
  assign grant_d    = d_req && !(if_req && starve_sat);
  assign grant_if   = if_req && !grant_d;
  assign starve_inc = (state == IDLE) && if_req && d_req && grant_d;
  assign starve_clr = (state == IDLE) && grant_if;

  mem_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clock (clock),
    .rst   (rst),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .sat   (starve_sat)
  );

  always_comb begin
    state_nxt     = state;
    acc_owner_nxt = acc_owner;
    acc_we_nxt    = acc_we;
    lat_nxt       = lat_cnt;
    addr_nxt      = mem_addr;
    wdata_nxt     = mem_wdata;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    if_gnt_nxt    = 1'b0;
    d_gnt_nxt     = 1'b0;
    if_done_nxt   = 1'b0;
    d_done_nxt    = 1'b0;
    en_nxt        = 1'b0;
    we_nxt        = 1'b0;

    case (state)
      IDLE: begin
        if (grant_d || grant_if) begin
          state_nxt     = ISSUE;
          acc_owner_nxt = grant_d ? OWN_D : OWN_IF;
          acc_we_nxt    = grant_d && d_we;
          addr_nxt      = grant_d ? d_addr : if_addr;
          if (grant_d) begin
            wdata_nxt = d_wdata;
          end
          d_gnt_nxt  = grant_d;
          if_gnt_nxt = grant_if;
          en_nxt     = 1'b1;
          we_nxt     = grant_d && d_we;
          lat_nxt    = LAT_W'(RD_LAT - 1);
        end
      end
      ISSUE: begin
        state_nxt = acc_we ? RESP : WAIT;
      end
      WAIT: begin
        // Read data is valid on the last WAIT cycle; capture into the owner's register.
        if (lat_cnt == '0) begin
          state_nxt = RESP;
          if (acc_owner == OWN_D) begin
            d_rdata_nxt = mem_rdata;
          end else begin
            if_rdata_nxt = mem_rdata;
          end
        end else begin
          lat_nxt = lat_cnt - LAT_W'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (state_nxt == RESP) begin
      if_done_nxt = (acc_owner == OWN_IF);
      d_done_nxt  = (acc_owner == OWN_D);
    end
    busy_nxt = (state_nxt != IDLE);
    lord_nxt = busy_nxt ? acc_owner_nxt : 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state     <= IDLE;
      acc_owner <= OWN_IF;
      acc_we    <= 1'b0;
      lat_cnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      lorD_mux  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc_owner <= acc_owner_nxt;
      acc_we    <= acc_we_nxt;
      lat_cnt   <= lat_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if_gnt    <= if_gnt_nxt;
      d_gnt     <= d_gnt_nxt;
      if_done   <= if_done_nxt;
      d_done    <= d_done_nxt;
      mem_en    <= en_nxt;
      mem_we    <= we_nxt;
      lorD_mux  <= lord_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (arbitration rule, latency formula, shadow memory).
module tb_mips_mem_arbiter;

  localparam int unsigned SMAX = 4;
  localparam int unsigned LAT  = 1;
  localparam int unsigned LAT3 = 3;

  logic        clock;
  logic        rst;
  logic        if_req, if_gnt, if_done, d_req, d_we, d_gnt, d_done;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, lorD_mux, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if_req3, if_gnt3, if_done3, d_req3, d_we3, d_gnt3, d_done3;
  logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3;
  logic        mem_en3, mem_we3, lorD_mux3, busy3;
  logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;

  int errors = 0;
  int checks = 0;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clock(clock), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lorD_mux(lorD_mux), .busy(busy)
  );

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT3), .STARVE_MAX(SMAX)) u_dut3 (
    .clock(clock), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_done(if_done3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_done(d_done3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .lorD_mux(lorD_mux3), .busy(busy3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM environment: read data appears on the bus only exactly RD_LAT cycles after the enable cycle.
  logic [31:0] ram    [256];
  logic [31:0] shadow [256];
  int          cyc     = 0;
  int          rd_cyc  = -100;
  int          rd_cyc3 = -100;
  logic [31:0] rd_word = 32'h0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mem_en && mem_we) ram[mem_addr[9:2]] = mem_wdata;
    if (mem_en && !mem_we) begin
      rd_word = ram[mem_addr[9:2]];
      rd_cyc  = cyc + int'(LAT);
    end
    if (mem_en3 && !mem_we3) rd_cyc3 = cyc + int'(LAT3);
  end

  assign mem_rdata  = (cyc == rd_cyc)  ? rd_word      : (32'hBAD0_0000 ^ 32'(cyc));
  assign mem_rdata3 = (cyc == rd_cyc3) ? 32'h1234_5678 : (32'h5A5A_0000 ^ 32'(cyc));

  task automatic apply_reset();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clock);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({if_gnt, d_gnt, if_done, d_done, mem_en, mem_we, lorD_mux, busy} !== 8'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {if_gnt, d_gnt, if_done, d_done, mem_en, mem_we, lorD_mux, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h expected all zero", mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    checks++;
    if ({busy3, mem_en3, if_gnt3, d_gnt3, lorD_mux3} !== 5'h0 || {if_rdata3, mem_wdata3} !== 64'h0) begin
      errors++;
      $display("FAIL reset_dut3: got busy=%b en=%b rdata=%h wdata=%h expected zeros",
               busy3, mem_en3, if_rdata3, mem_wdata3);
    end
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h40;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) if_req = 1'b0;
      checks++;
      if (if_gnt !== (k == 1) || if_done !== (k == 3) || d_gnt !== 1'b0 || d_done !== 1'b0) begin
        errors++;
        $display("FAIL fetch_pulses k=%0d: got gnt=%b done=%b expected gnt=%b done=%b",
                 k, if_gnt, if_done, (k == 1), (k == 3));
      end
      checks++;
      if (mem_en !== (k == 1) || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL fetch_strobe k=%0d: got en=%b we=%b expected en=%b we=0", k, mem_en, mem_we, (k == 1));
      end
      checks++;
      if (busy !== (k <= 3) || lorD_mux !== 1'b0 || (k <= 3 && mem_addr !== 32'h40)) begin
        errors++;
        $display("FAIL fetch_hold k=%0d: got busy=%b lorD=%b addr=%h expected busy=%b lorD=0 addr=40",
                 k, busy, lorD_mux, mem_addr, (k <= 3));
      end
      if (k == 3) begin
        checks++;
        if (if_rdata !== 32'h2008_000A) begin
          errors++;
          $display("FAIL fetch_rdata: got %h expected 2008000a", if_rdata);
        end
      end
    end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (k == 1) d_req = 1'b0;
      checks++;
      if (d_gnt !== (k == 1) || d_done !== (k == 2) || if_gnt !== 1'b0 || if_done !== 1'b0) begin
        errors++;
        $display("FAIL store_pulses k=%0d: got gnt=%b done=%b expected gnt=%b done=%b",
                 k, d_gnt, d_done, (k == 1), (k == 2));
      end
      checks++;
      if (mem_en !== (k == 1) || mem_we !== (k == 1) || lorD_mux !== (k <= 2) || busy !== (k <= 2)) begin
        errors++;
        $display("FAIL store_ctrl k=%0d: got en=%b we=%b lorD=%b busy=%b", k, mem_en, mem_we, lorD_mux, busy);
      end
      if (k <= 2) begin
        checks++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL store_bus k=%0d: got addr=%h wdata=%h expected 100 deadbeef", k, mem_addr, mem_wdata);
        end
      end
      checks++;
      if (d_rdata !== 32'h0) begin
        errors++;
        $display("FAIL store_rdata k=%0d: got %h expected 0", k, d_rdata);
      end
    end
  endtask

  task automatic test_req_during_busy();
    if_req = 1'b1; if_addr = 32'h48;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) begin if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4C; end
      if (k == 2) d_req = 1'b0;
      checks++;
      if (d_gnt !== 1'b0 || d_done !== 1'b0) begin
        errors++;
        $display("FAIL busy_ignore k=%0d: got d_gnt=%b d_done=%b expected 0 0", k, d_gnt, d_done);
      end
      if (k == 3) begin
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 32'h3C0B_1234) begin
          errors++;
          $display("FAIL busy_fetch: got done=%b rdata=%h expected 1 3c0b1234", if_done, if_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    if_req = 1'b1; if_addr = 32'h44;
    @(negedge clock); if_req = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL midwait_pre: got busy=%b en=%b expected 1 0", busy, mem_en);
    end
    rst = 1'b0;
    @(negedge clock);
    checks++;
    if ({if_gnt, d_gnt, if_done, d_done, mem_en, mem_we, lorD_mux, busy} !== 8'h0 ||
        {mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL midwait_reset: got ctrl=%b addr=%h wdata=%h ifr=%h dr=%h expected zeros",
               {if_gnt, d_gnt, if_done, d_done, mem_en, mem_we, lorD_mux, busy},
               mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (if_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midwait_drop k=%0d: got done=%b busy=%b expected 0 0", k, if_done, busy);
      end
    end
    if_req = 1'b1; if_addr = 32'h44;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) if_req = 1'b0;
      checks++;
      if (if_gnt !== (k == 1) || if_done !== (k == 3) || (k == 3 && if_rdata !== 32'hCAFE_0011)) begin
        errors++;
        $display("FAIL midwait_fresh k=%0d: got gnt=%b done=%b rdata=%h expected rdata cafe0011 at k=3",
                 k, if_gnt, if_done, if_rdata);
      end
    end
  endtask

  task automatic test_starvation();
    int got = 0;
    apply_reset();
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84;
    for (int c = 0; c < 200 && got < 10; c++) begin
      @(negedge clock);
      if (if_gnt || d_gnt) begin
        checks++;
        if ({if_gnt, d_gnt} !== ((got % 5 == 4) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL starve_grant #%0d: got if_gnt,d_gnt=%b expected %b",
                   got, {if_gnt, d_gnt}, ((got % 5 == 4) ? 2'b10 : 2'b01));
        end
        got++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    checks++;
    if (got != 10) begin
      errors++;
      $display("FAIL starve_timeout: got %0d grants expected 10", got);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL starve_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_rdlat3();
    d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h200;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 1) d_req3 = 1'b0;
      checks++;
      if (d_gnt3 !== (k == 1) || d_done3 !== (k == 5) || mem_en3 !== (k == 1) || mem_we3 !== 1'b0 ||
          if_gnt3 !== 1'b0 || if_done3 !== 1'b0) begin
        errors++;
        $display("FAIL lat3_pulses k=%0d: got gnt=%b done=%b en=%b expected gnt=%b done=%b en=%b",
                 k, d_gnt3, d_done3, mem_en3, (k == 1), (k == 5), (k == 1));
      end
      checks++;
      if (busy3 !== (k <= 5) || lorD_mux3 !== (k <= 5) || (k <= 5 && mem_addr3 !== 32'h200)) begin
        errors++;
        $display("FAIL lat3_hold k=%0d: got busy=%b lorD=%b addr=%h", k, busy3, lorD_mux3, mem_addr3);
      end
      checks++;
      if (d_rdata3 !== ((k >= 5) ? 32'h1234_5678 : 32'h0)) begin
        errors++;
        $display("FAIL lat3_rdata k=%0d: got %h expected %h", k, d_rdata3, ((k >= 5) ? 32'h1234_5678 : 32'h0));
      end
    end
  endtask

  task automatic test_random();
    int          gnt_at = -1, done_at = -1, free_at = 0, scnt = 0;
    logic        own = 1'b0, rd = 1'b0, if_out = 1'b0, d_out = 1'b0, busy_e;
    logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0, m_if_rdata = 0, m_d_rdata = 0;
    apply_reset();
    for (int i = 0; i < 256; i++) shadow[i] = ram[i];
    for (int n = 0; n < 800; n++) begin
      @(negedge clock);
      busy_e = (n >= gnt_at) && (n <= done_at);
      if (n == done_at && rd) begin
        if (own) m_d_rdata = e_rdata; else m_if_rdata = e_rdata;
      end
      checks++;
      if ({if_gnt, d_gnt, if_done, d_done} !==
          {n == gnt_at && !own, n == gnt_at && own, n == done_at && !own, n == done_at && own}) begin
        errors++;
        $display("FAIL rand_pulses n=%0d: got gnt=%b%b done=%b%b expected gnt_at=%0d done_at=%0d own=%b",
                 n, if_gnt, d_gnt, if_done, d_done, gnt_at, done_at, own);
      end
      checks++;
      if ({mem_en, mem_we, busy, lorD_mux} !== {n == gnt_at, n == gnt_at && !rd, busy_e, busy_e && own}) begin
        errors++;
        $display("FAIL rand_ctrl n=%0d: got en=%b we=%b busy=%b lorD=%b expected busy=%b own=%b",
                 n, mem_en, mem_we, busy, lorD_mux, busy_e, own);
      end
      if (busy_e) begin
        checks++;
        if (mem_addr !== e_addr || (own && !rd && mem_wdata !== e_wdata)) begin
          errors++;
          $display("FAIL rand_bus n=%0d: got addr=%h wdata=%h expected addr=%h wdata=%h",
                   n, mem_addr, mem_wdata, e_addr, e_wdata);
        end
      end
      checks++;
      if (if_rdata !== m_if_rdata || d_rdata !== m_d_rdata) begin
        errors++;
        $display("FAIL rand_rdata n=%0d: got if=%h d=%h expected if=%h d=%h",
                 n, if_rdata, d_rdata, m_if_rdata, m_d_rdata);
      end
      // Requesters: hold until granted, drop after grant, new access only after done.
      if (n == gnt_at) begin
        if (own) begin d_req = 1'b0; d_out = 1'b1; end
        else     begin if_req = 1'b0; if_out = 1'b1; end
      end
      if (n == done_at) begin
        if (own) d_out = 1'b0; else if_out = 1'b0;
      end
      if (!if_req && !if_out && $urandom_range(2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!d_req && !d_out && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
      end
      // Model: decide the next transaction when the arbiter is idle.
      if (n >= free_at && (if_req || d_req)) begin
        own = d_req && !(if_req && scnt >= int'(SMAX));
        if (if_req && own && scnt < int'(SMAX)) scnt++;
        if (!own) scnt = 0;
        rd      = !own || !d_we;
        e_addr  = own ? d_addr : if_addr;
        e_wdata = d_wdata;
        gnt_at  = n + 1;
        done_at = n + 2 + (rd ? int'(LAT) : 0);
        free_at = done_at + 1;
        if (rd) e_rdata = shadow[e_addr[9:2]];
        else    shadow[e_addr[9:2]] = d_wdata;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    if_req3 = 1'b0; if_addr3 = 32'h0; d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = 32'h0; d_wdata3 = 32'h0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + 32'(i);
    ram[8'h10] = 32'h2008_000A;
    ram[8'h11] = 32'hCAFE_0011;
    ram[8'h12] = 32'h3C0B_1234;
    test_reset();
    test_single_fetch();
    test_store();
    test_req_during_busy();
    test_reset_mid_wait();
    test_starvation();
    test_rdlat3();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
